// File: rtl/c4_pkg.sv
// Shared types and board geometry defaults for the Connect Four drop controller.
package c4_pkg;

  localparam int unsigned COLS_DEF  = 7;
  localparam int unsigned ROWS_DEF  = 6;
  localparam int unsigned COL_W_DEF = 3;
  localparam int unsigned ROW_W_DEF = 3;
  localparam int unsigned CNT_W     = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    PLACE  = 3'd2,
    REJECT = 3'd3,
    FULL   = 3'd4
  } drop_state_t;

  typedef logic player_t;
  localparam player_t RED = 1'b0;
  localparam player_t GRN = 1'b1;

  typedef logic [ROW_W_DEF-1:0] height_t;

endpackage

// File: rtl/column_drop_ctrl_if.sv
// Drop request / placement bus between the game front end (master) and the drop controller (slave).
interface column_drop_ctrl_if
  import c4_pkg::*;
#(
  parameter int unsigned COL_W = COL_W_DEF,
  parameter int unsigned ROW_W = ROW_W_DEF
);

  logic               drop_req;
  logic [COL_W-1:0]   drop_col;
  logic               drop_ready;
  logic               place_valid;
  logic [COL_W-1:0]   place_col;
  logic [ROW_W-1:0]   place_row;
  player_t            place_player;
  logic               reject;
  player_t            cur_player;
  logic               board_full;
  logic [CNT_W-1:0]   move_count;

  modport master (
    output drop_req, drop_col,
    input  drop_ready, place_valid, place_col, place_row, place_player,
           reject, cur_player, board_full, move_count
  );

  modport slave (
    input  drop_req, drop_col,
    output drop_ready, place_valid, place_col, place_row, place_player,
           reject, cur_player, board_full, move_count
  );

endinterface

// File: rtl/drop_input_sync.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous drop button.
module drop_input_sync (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise_c
);

  logic [2:0] sh;

  always_ff @(posedge clk) begin
    if (reset) sh <= '0;
    else       sh <= {sh[1:0], level};
  end

  // sh[1] is the synchronised level, sh[2] its previous value
  assign rise_c = sh[1] & ~sh[2];

endmodule

// File: rtl/column_drop_ctrl.sv
// Column drop controller: finds the lowest free row, emits placements, tracks turns and fullness.
// Optional COLUMN_DROP_SYNC_EN: treat drop_req as an asynchronous button level.
module column_drop_ctrl
  import c4_pkg::*;
#(
  parameter int unsigned COLS  = COLS_DEF,
  parameter int unsigned ROWS  = ROWS_DEF,
  parameter int unsigned COL_W = COL_W_DEF,
  parameter int unsigned ROW_W = ROW_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  column_drop_ctrl_if.slave  bus
);

  localparam int unsigned CELLS = ROWS * COLS;

  logic req;

`ifdef COLUMN_DROP_SYNC_EN
  drop_input_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .level  (bus.drop_req),
    .rise_c (req)
  );
`else
  assign req = bus.drop_req;
`endif

  drop_state_t        state, state_nxt;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   heights [COLS];
  logic [ROW_W-1:0]   height_sel;
  logic               col_ok;
  logic               col_full;

  logic               drop_ready, place_valid, reject, board_full;
  logic               ready_nxt, valid_nxt, reject_nxt, full_nxt;
  logic [COL_W-1:0]   place_col;
  logic [ROW_W-1:0]   place_row;
  player_t            place_player, cur_player;
  logic [CNT_W-1:0]   move_count;

  // Height of the latched column; out-of-range columns read as empty and are rejected
  always_comb begin
    height_sel = '0;
    col_ok     = (32'(col_q) < COLS);
    for (int i = 0; i < int'(COLS); i++) begin
      if (col_q == COL_W'(i)) height_sel = heights[i];
    end
    col_full = (height_sel == ROW_W'(ROWS));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = CHECK;
      CHECK:   state_nxt = (!col_ok || col_full) ? REJECT : PLACE;
      PLACE:   state_nxt = ((32'(move_count) + 32'd1) == CELLS) ? FULL : IDLE;
      REJECT:  state_nxt = IDLE;
      FULL:    state_nxt = FULL;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered copies of the decoded next state
  always_comb begin
    ready_nxt  = 1'b0;
    valid_nxt  = 1'b0;
    reject_nxt = 1'b0;
    full_nxt   = 1'b0;
    case (state_nxt)
      IDLE:    ready_nxt  = 1'b1;
      PLACE:   valid_nxt  = 1'b1;
      REJECT:  reject_nxt = 1'b1;
      FULL:    full_nxt   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_ready   <= 1'b1;
      place_valid  <= 1'b0;
      reject       <= 1'b0;
      board_full   <= 1'b0;
      col_q        <= '0;
      place_col    <= '0;
      place_row    <= '0;
      place_player <= RED;
      cur_player   <= RED;
      move_count   <= '0;
      for (int i = 0; i < int'(COLS); i++) heights[i] <= '0;
    end else begin
      drop_ready  <= ready_nxt;
      place_valid <= valid_nxt;
      reject      <= reject_nxt;
      board_full  <= full_nxt;
      if (state == IDLE && req) col_q <= bus.drop_col;
      if (state == CHECK && state_nxt == PLACE) begin
        place_col    <= col_q;
        place_row    <= height_sel;
        place_player <= cur_player;
      end
      // Commit the move as the placement pulse ends
      if (state == PLACE) begin
        cur_player <= ~cur_player;
        if (32'(move_count) < CELLS) move_count <= move_count + CNT_W'(1);
        for (int i = 0; i < int'(COLS); i++) begin
          if (col_q == COL_W'(i) && heights[i] != ROW_W'(ROWS))
            heights[i] <= heights[i] + ROW_W'(1);
        end
      end
    end
  end

  assign bus.drop_ready   = drop_ready;
  assign bus.place_valid  = place_valid;
  assign bus.place_col    = place_col;
  assign bus.place_row    = place_row;
  assign bus.place_player = place_player;
  assign bus.reject       = reject;
  assign bus.cur_player   = cur_player;
  assign bus.board_full   = board_full;
  assign bus.move_count   = move_count;

endmodule

// File: tb/tb_column_drop_ctrl.sv
// Scoreboard bench for column_drop_ctrl: drops push expected pulses, a negedge monitor checks them.
module tb_column_drop_ctrl;
  import c4_pkg::*;

  logic clk;
  logic reset;

  column_drop_ctrl_if #(.COL_W(3), .ROW_W(3)) bus ();

  column_drop_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit is_place;
    int col;
    int row;
    int player;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  int   mh[7];
  int   mp;
  int   mc;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 7; i++) mh[i] = 0;
    mp = 0;
    mc = 0;
  endfunction

  function automatic void push_expect(input int col);
    exp_t e;
    if (col >= 7 || mh[col] == 6) begin
      e.is_place = 1'b0; e.col = 0; e.row = 0; e.player = 0;
    end else begin
      e.is_place = 1'b1; e.col = col; e.row = mh[col]; e.player = mp;
      mh[col]++;
      mp = 1 - mp;
      mc++;
    end
    sb.push_back(e);
  endfunction

  // Monitor: every placement/reject pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && (bus.place_valid || bus.reject)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind", int'(bus.place_valid), int'(mon_e.is_place));
        check("pulse_excl", int'(bus.place_valid & bus.reject), 0);
        if (mon_e.is_place) begin
          check("place_col", int'(bus.place_col), mon_e.col);
          check("place_row", int'(bus.place_row), mon_e.row);
          check("place_player", int'(bus.place_player), mon_e.player);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.drop_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", int'(bus.drop_ready), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    sb.delete();
  endtask

  task automatic drop(input int col);
    wait_ready();
    push_expect(col);
    bus.drop_col = 3'(col);
    bus.drop_req = 1'b1;
`ifdef COLUMN_DROP_SYNC_EN
    repeat (3) @(posedge clk);
`else
    @(posedge clk);
`endif
    #1 bus.drop_req = 1'b0;
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.drop_req = 1'b0;
    bus.drop_col = '0;
    model_reset();
    do_reset();

    @(negedge clk);
    check("rst_ready", int'(bus.drop_ready), 1);
    check("rst_valid", int'(bus.place_valid), 0);
    check("rst_reject", int'(bus.reject), 0);
    check("rst_full", int'(bus.board_full), 0);
    check("rst_player", int'(bus.cur_player), 0);
    check("rst_count", int'(bus.move_count), 0);
    check("rst_row", int'(bus.place_row), 0);

    // Single drop into column 3
    drop(3);
    wait_ready();
    check("t1_cur_player", int'(bus.cur_player), 1);
    check("t1_count", int'(bus.move_count), 1);
    check("t1_hold_col", int'(bus.place_col), 3);
    check("t1_hold_row", int'(bus.place_row), 0);

    // Fill column 0, then overflow it
    do_reset();
    for (int k = 0; k < 7; k++) drop(0);
    wait_ready();
    check("t2_cur_player", int'(bus.cur_player), 0);
    check("t2_count", int'(bus.move_count), 6);
    check("t2_hold_row", int'(bus.place_row), 5);

    // Out-of-range column, then a normal drop elsewhere
    drop(7);
    wait_ready();
    check("t3_count", int'(bus.move_count), 6);
    check("t3_cur_player", int'(bus.cur_player), 0);
    drop(1);
    wait_ready();
    check("t3_col1_count", int'(bus.move_count), 7);

    // Request held high across CHECK/PLACE gives one placement
    wait_ready();
    push_expect(4);
    bus.drop_col = 3'd4;
    bus.drop_req = 1'b1;
`ifdef COLUMN_DROP_SYNC_EN
    repeat (20) @(posedge clk);
`else
    repeat (3) @(posedge clk);
`endif
    #1 bus.drop_req = 1'b0;
    repeat (6) @(negedge clk);
    wait_ready();
    check("t6_count", int'(bus.move_count), 8);

    // Reset during CHECK discards the pending placement
    wait_ready();
    bus.drop_col = 3'd0;
    bus.drop_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.drop_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_in_check", int'(bus.drop_ready), 0);
    bus.drop_req = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("t5_no_valid", int'(bus.place_valid), 0);
    check("t5_ready", int'(bus.drop_ready), 1);
    check("t5_count", int'(bus.move_count), 0);
    drop(0);
    wait_ready();
    check("t5_col0_row", int'(bus.place_row), 0);

    // Fill the whole board
    do_reset();
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++) drop(c);
    repeat (6) @(negedge clk);
    check("t4_full", int'(bus.board_full), 1);
    check("t4_ready", int'(bus.drop_ready), 0);
    check("t4_count", int'(bus.move_count), 42);
    check("t4_cur_player", int'(bus.cur_player), 0);
    bus.drop_col = 3'd2;
    bus.drop_req = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus.drop_req = 1'b0;
    repeat (8) @(negedge clk);
    check("t4_still_full", int'(bus.board_full), 1);
    check("t4_count_hold", int'(bus.move_count), 42);

    repeat (5) @(negedge clk);
    check("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
